// File: rtl/axi_repacketize_pkg.sv
// Shared types and helpers for the AXI-Stream re-packetizer: default widths,
// the buffered beat record and the samples-per-packet normalisation.
package axi_repacketize_pkg;

   localparam int SPP_W_DEFAULT = 16;
   localparam int WIDTH_DEFAULT = 32;

   typedef struct packed {
      logic [WIDTH_DEFAULT-1:0] data;
      logic                     last;
   } beat_t;

   // A packet length of zero would never close a packet, so it behaves as one.
   function automatic logic [SPP_W_DEFAULT-1:0] spp_eff(input logic [SPP_W_DEFAULT-1:0] spp);
      return (spp == '0) ? SPP_W_DEFAULT'(1) : spp;
   endfunction

endpackage

// File: rtl/axi_skid_reg.sv
// Two-entry registered AXI-Stream buffer (output register plus skid slot) with
// synchronous flush and asynchronous active-low reset.
module axi_skid_reg
   import axi_repacketize_pkg::*;
(
   input  logic  clk,
   input  logic  reset_n,
   input  logic  clear,
   input  beat_t in_beat,
   input  logic  in_valid,
   output logic  in_ready,
   output beat_t out_beat,
   output logic  out_valid,
   input  logic  out_ready
);

   beat_t out_q, out_d;
   beat_t skid_q, skid_d;
   logic  out_vld_q, out_vld_d;
   logic  skid_vld_q, skid_vld_d;
   logic  rdy_q, rdy_d;
   logic  push, pop;

   // Ready comes from a flop so downstream ready never reaches upstream combinationally.
   assign in_ready  = rdy_q & ~clear;
   assign push      = in_valid & in_ready;
   assign pop       = out_vld_q & out_ready;
   assign out_beat  = out_q;
   assign out_valid = out_vld_q;

   always_comb begin
      out_d      = out_q;
      skid_d     = skid_q;
      out_vld_d  = out_vld_q;
      skid_vld_d = skid_vld_q;
      if (clear) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!out_vld_q || pop) begin
         if (skid_vld_q) begin
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = push;
            if (push) skid_d = in_beat;
         end else begin
            out_vld_d = push;
            if (push) out_d = in_beat;
         end
      end else if (push) begin
         skid_d     = in_beat;
         skid_vld_d = 1'b1;
      end
      rdy_d = ~skid_vld_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
         rdy_q      <= rdy_d;
      end
   end

   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

endmodule

// File: rtl/axi_repacketize.sv
// Re-frames a sample stream into packets of spp samples by regenerating tlast,
// optionally ending packets early on input tlast. Optional statistics outputs
// are enabled by defining AXI_REPACKETIZE_STATS_EN.
module axi_repacketize
   import axi_repacketize_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int SPP_W = SPP_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic [SPP_W-1:0] spp,
   input  logic             honor_tlast,
   input  logic [WIDTH-1:0] i_tdata,
   input  logic             i_tlast,
   input  logic             i_tvalid,
   output logic             i_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready
`ifdef AXI_REPACKETIZE_STATS_EN
   ,
   output logic [31:0]      pkt_count,
   output logic [31:0]      short_count
`endif
);

   logic [SPP_W-1:0] cnt_q, cnt_d;
   logic [SPP_W-1:0] lat_q, lat_d, lat_cur;
   logic             accept, at_limit, out_last;
   beat_t            in_beat, out_beat;

   assign accept = i_tvalid & i_tready;

   // The first beat of a packet latches spp and is judged against that new length.
   always_comb begin
      lat_cur  = (cnt_q == '0) ? SPP_W'(spp_eff(SPP_W_DEFAULT'(spp))) : lat_q;
      at_limit = (cnt_q == lat_cur - 1'b1);
      out_last = at_limit | (honor_tlast & i_tlast);
      cnt_d    = cnt_q;
      lat_d    = lat_q;
      if (clear) begin
         cnt_d = '0;
      end else if (accept) begin
         lat_d = lat_cur;
         cnt_d = out_last ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         lat_q <= SPP_W'(1);
      end else begin
         cnt_q <= cnt_d;
         lat_q <= lat_d;
      end
   end

   assign in_beat = '{data: i_tdata, last: out_last};

   axi_skid_reg u_skid (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .in_beat  (in_beat),
      .in_valid (i_tvalid),
      .in_ready (i_tready),
      .out_beat (out_beat),
      .out_valid(o_tvalid),
      .out_ready(o_tready)
   );

   assign o_tdata = out_beat.data;
   assign o_tlast = out_beat.last;

`ifdef AXI_REPACKETIZE_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && v != '1) ? v + 32'd1 : v;
   endfunction

   // A short packet is one closed by honoured input tlast before reaching its length.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pkt_count   <= '0;
         short_count <= '0;
      end else if (clear) begin
         pkt_count   <= '0;
         short_count <= '0;
      end else begin
         pkt_count   <= sat_inc(pkt_count, o_tvalid & o_tready & o_tlast);
         short_count <= sat_inc(short_count, accept & honor_tlast & i_tlast & ~at_limit);
      end
   end
`endif

endmodule

// File: doc/axi_repacketize.md
Name: axi_repacketize

Overview:
- Downstream of the keep-one-in-N decimator.
- Takes its 32-bit sample stream, whose packets may be short or irregular in sample mode, and re-frames it into output packets of exactly SPP samples by regenerating tlast.
- Optionally honours input tlast to end a packet early, so vector boundaries are preserved.
- Sits between the decimator and the AXI wrapper's s_axis_data port.

Parameters:
- WIDTH, 32, sample data width in bits.
- SPP_W, 16, width of the spp setting and of the internal beat counter.

Ports:
- clk  in  1  block clock; all logic is in this single domain.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush: drops buffered beats and resets the beat counter.
- spp  in  SPP_W  samples per output packet; 0 is treated as 1.
- honor_tlast  in  1  1 = input tlast also terminates the output packet.
- i_tdata  in  WIDTH  input sample.
- i_tlast  in  1  input end of packet.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  WIDTH  output sample.
- o_tlast  out  1  regenerated end of packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.

Behaviour:
- Reset (reset_n low, asynchronous):
  - o_tvalid=0, o_tlast=0, o_tdata=0.
  - Beat counter=0, spp_lat=1, skid buffer empty.
  - i_tready=0 while reset_n is low, and 1 in the first cycle after release.
- Handshake: standard AXI-Stream. A beat transfers when valid&ready on the same edge. o_tdata and o_tlast are held stable while o_tvalid&!o_tready.
- Pipeline:
  - 2-entry skid register; all outputs are registered.
  - Latency: 1 cycle from input accept to o_tvalid.
  - Full throughput: one beat per clock under continuous o_tready.
  - i_tready = skid not full; it depends only on registered state, with no combinational path from o_tready.
- Counter:
  - cnt counts beats accepted in the current output packet.
  - On the first beat of a packet (cnt==0), spp_lat <= (spp==0 ? 1 : spp), and that beat's boundary test uses this new value.
  - A spp change mid-packet has no effect until the next packet.
- tlast generation: for an accepted beat, out_last = (cnt==spp_lat-1) | (honor_tlast & i_tlast).
  - If out_last: cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - cnt is SPP_W bits. With spp=2^SPP_W-1, tlast occurs at cnt=2^SPP_W-2; cnt never wraps unguarded.
- honor_tlast=0: input tlast is ignored; packets are exactly spp_lat beats.
- Simultaneous events: when the spp boundary and input tlast coincide, a single tlast is emitted and cnt <= 0.
- clear:
  - Takes priority over any transfer that cycle.
  - Empties the skid (o_tvalid=0 next cycle) and sets cnt=0.
  - The input beat presented that cycle is not accepted (i_tready=0 during clear).
  - Used with clear_tx_seqnum to discard partial packets on block restart.
- Reset mid-packet: same as clear, but asynchronous; no partial packet is emitted afterwards.
- Data path: i_tdata passes unmodified; no samples are dropped or reordered.

Optional Feature:
- Macro: AXI_REPACKETIZE_STATS_EN.
- When defined, adds outputs:
  - pkt_count[31:0]: output packets completed, counted on o_tvalid&o_tready&o_tlast.
  - short_count[31:0]: packets terminated by honoured input tlast before reaching spp_lat beats.
  - Both counters saturate at 2^32-1, and are reset by reset_n or clear.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package axi_repacketize_pkg:
  - SPP_W_DEFAULT=16 and WIDTH_DEFAULT=32.
  - Beat struct {data, last} used by the skid register.
  - Function spp_eff(spp), which maps 0 to 1.
- Sub-module axi_skid_reg: 2-entry registered AXI-Stream buffer with sync clear and async active-low reset. It owns i_tready/o_tvalid timing. The top level holds the counter and tlast logic.

Test Plan:
- spp=4, honor_tlast=0, 10 continuous beats D0..D9, o_tready=1 → tlast on D3 and D7; D8,D9 pending with cnt=2; first o_tvalid 1 cycle after D0 accepted.
- spp=4, honor_tlast=1, input tlast on D1 → output tlast on D1; next packet D2..D5 with tlast on D5; short_count=1 (STATS_EN).
- spp=0, 3 beats → tlast on every beat; pkt_count=3.
- spp=3, o_tready toggling 1,0,0,1 while input streams → no beat lost or duplicated; i_tready drops to 0 once the skid holds 2 beats; o_tdata is stable during stalls.
- spp changes from 4 to 2 after 2 beats of a packet → current packet still ends at beat 4; the next packet has 2 beats.
- clear asserted with 2 beats buffered and cnt=2 → next cycle o_tvalid=0 and cnt=0; a subsequent spp=4 packet ends tlast on its 4th beat. Repeat the scenario using reset_n low mid-packet → same result.
